tv_sync_gen: RTL and testbench

//  Raster timing generator for the composite TV output path; directly upstream of the video processing unit.

---
 rtl/tv_sync_gen.sv | 93 +++++++++
 tb/tb_tv_sync_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tv_sync_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tv_sync_gen                                                |
// | Description : Raster timing generator: 9-bit H/V counters, blanking      |
// |               flags, serrated composite sync and line/frame pulses.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tv_sync_gen #(
   parameter int H_TOTAL      = 384,
   parameter int H_HALF       = 192,
   parameter int H_SYNC       = 28,
   parameter int H_BLANK      = 72,
   parameter int V_TOTAL      = 312,
   parameter int V_SYNC_LINES = 3,
   parameter int V_BLANK      = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   output logic [8:0] cnt_hs,
   output logic [8:0] cnt_vs,
   output logic       hsync,
   output logic       vbl,
   output logic       out_sync,
   output logic       line_start,
   output logic       frame_start
);

   localparam logic [8:0] c_h_last      = 9'(H_TOTAL - 1);
   localparam logic [8:0] c_v_last      = 9'(V_TOTAL - 1);
   localparam logic [8:0] c_h_sync      = 9'(H_SYNC);
   localparam logic [8:0] c_h_blank     = 9'(H_BLANK);
   localparam logic [8:0] c_h_half      = 9'(H_HALF);
   localparam logic [8:0] c_broad_end_0 = 9'(H_HALF - H_SYNC);
   localparam logic [8:0] c_broad_end_1 = 9'(H_TOTAL - H_SYNC);
   localparam logic [8:0] c_v_sync      = 9'(V_SYNC_LINES);
   localparam logic [8:0] c_v_blank     = 9'(V_BLANK);

   logic [8:0] r_hs;
   logic [8:0] r_vs;
   logic       r_hsync;
   logic       r_vbl;
   logic       r_sync;
   logic       r_line_start;
   logic       r_frame_start;

   logic       w_h_wrap;
   logic       w_v_wrap;
   logic [8:0] w_hs_nxt;
   logic [8:0] w_vs_nxt;
   logic       w_broad;
   logic       w_sync_nxt;

   assign w_h_wrap = (r_hs == c_h_last);
   assign w_v_wrap = w_h_wrap && (r_vs == c_v_last);
   assign w_hs_nxt = w_h_wrap ? 9'd0 : r_hs + 9'd1;
   assign w_vs_nxt = w_v_wrap ? 9'd0 : (w_h_wrap ? r_vs + 9'd1 : r_vs);

   // Flags are decoded from the next-state counters so they line up with them.
   assign w_broad = (w_hs_nxt < c_broad_end_0) ||
                    ((w_hs_nxt >= c_h_half) && (w_hs_nxt < c_broad_end_1));
   assign w_sync_nxt = (w_vs_nxt < c_v_sync) ? ~w_broad : (w_hs_nxt >= c_h_sync);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs          <= 9'd0;
         r_vs          <= 9'd0;
         r_hsync       <= 1'b1;
         r_vbl         <= 1'b1;
         r_sync        <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (ce) begin
         r_hs          <= w_hs_nxt;
         r_vs          <= w_vs_nxt;
         r_hsync       <= (w_hs_nxt < c_h_blank);
         r_vbl         <= (w_vs_nxt < c_v_blank);
         r_sync        <= w_sync_nxt;
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
      end
   end

   assign cnt_hs      = r_hs;
   assign cnt_vs      = r_vs;
   assign hsync       = r_hsync;
   assign vbl         = r_vbl;
   assign out_sync    = r_sync;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_tv_sync_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tv_sync_gen                                             |
// | Description : Scoreboard bench for tv_sync_gen (default and small DUT).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tv_sync_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;

   logic [8:0] m_cnt_hs, m_cnt_vs, s_cnt_hs, s_cnt_vs;
   logic m_hsync, m_vbl, m_sync, m_ls, m_fs;
   logic s_hsync, s_vbl, s_sync, s_ls, s_fs;

   always #5 clk = ~clk;

   tv_sync_gen u_dut (
      .clk(clk), .rst(rst), .ce(ce),
      .cnt_hs(m_cnt_hs), .cnt_vs(m_cnt_vs), .hsync(m_hsync), .vbl(m_vbl),
      .out_sync(m_sync), .line_start(m_ls), .frame_start(m_fs)
   );

   // Small raster so that many full frames fit in the run.
   tv_sync_gen #(
      .H_TOTAL(40), .H_HALF(20), .H_SYNC(4), .H_BLANK(10),
      .V_TOTAL(10), .V_SYNC_LINES(2), .V_BLANK(4)
   ) u_small (
      .clk(clk), .rst(rst), .ce(ce),
      .cnt_hs(s_cnt_hs), .cnt_vs(s_cnt_vs), .hsync(s_hsync), .vbl(s_vbl),
      .out_sync(s_sync), .line_start(s_ls), .frame_start(s_fs)
   );

   typedef struct {
      logic r;
      logic c;
      int   mhs, mvs, mls, mfs;
      int   shs, svs, sls, sfs;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int failures = 0;

   int mhs = 0, mvs = 0, mls = 0, mfs = 0;
   int shs = 0, svs = 0, sls = 0, sfs = 0;

   // Hand-derived sync tables for the two rasters.
   function automatic logic main_sync(int hs, int vs);
      if (vs <= 2) return !((hs <= 163) || (hs >= 192 && hs <= 355));
      return !(hs <= 27);
   endfunction

   function automatic logic small_sync(int hs, int vs);
      if (vs <= 1) return !((hs <= 15) || (hs >= 20 && hs <= 35));
      return !(hs <= 3);
   endfunction

   task automatic step(input logic r, input logic c);
      exp_t e;
      @(negedge clk);
      rst = r;
      ce  = c;
      if (r) begin
         mhs = 0; mvs = 0; mls = 0; mfs = 0;
         shs = 0; svs = 0; sls = 0; sfs = 0;
      end else if (c) begin
         if (mhs == 383) begin
            mhs = 0; mls = 1;
            if (mvs == 311) begin mvs = 0; mfs = 1; end
            else begin mvs = mvs + 1; mfs = 0; end
         end else begin
            mhs = mhs + 1; mls = 0; mfs = 0;
         end
         if (shs == 39) begin
            shs = 0; sls = 1;
            if (svs == 9) begin svs = 0; sfs = 1; end
            else begin svs = svs + 1; sfs = 0; end
         end else begin
            shs = shs + 1; sls = 0; sfs = 0;
         end
      end
      e.r = r; e.c = c;
      e.mhs = mhs; e.mvs = mvs; e.mls = mls; e.mfs = mfs;
      e.shs = shs; e.svs = svs; e.sls = sls; e.sfs = sfs;
      q.push_back(e);
      @(posedge clk);
   endtask

   task automatic run_to(input int hs, input int vs);
      int n;
      n = 0;
      while (!(mhs == hs && mvs == vs) && n < 130000) begin
         step(1'b0, 1'b1);
         n++;
      end
      if (n >= 130000) begin
         failures++;
         $display("FAIL run_to(%0d,%0d) bound expired at (%0d,%0d)", hs, vs, mhs, mvs);
      end
   endtask

   // Monitor: pop one expectation per edge and compare both DUTs.
   int s_lines = 0;
   always @(posedge clk) begin
      exp_t e;
      logic [22:0] act, exp_v;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         act   = {m_cnt_hs, m_cnt_vs, m_hsync, m_vbl, m_sync, m_ls, m_fs};
         exp_v = {9'(e.mhs), 9'(e.mvs), (e.mhs <= 71), (e.mvs <= 23),
                  main_sync(e.mhs, e.mvs), e.mls[0], e.mfs[0]};
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL main_outputs at t=%0t actual=%h required=%h", $time, act, exp_v);
         end
         act   = {s_cnt_hs, s_cnt_vs, s_hsync, s_vbl, s_sync, s_ls, s_fs};
         exp_v = {9'(e.shs), 9'(e.svs), (e.shs <= 9), (e.svs <= 3),
                  small_sync(e.shs, e.svs), e.sls[0], e.sfs[0]};
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL small_outputs at t=%0t actual=%h required=%h", $time, act, exp_v);
         end
         if (e.r) s_lines = 0;
         else if (e.c) begin
            if (s_ls === 1'b1) s_lines++;
            if (s_fs === 1'b1) begin
               checks++;
               if (s_lines != 10) begin
                  failures++;
                  $display("FAIL small_lines_per_frame actual=%0d required=10", s_lines);
               end
               s_lines = 0;
            end
         end
      end
   end

   initial begin
      repeat (5) step(1'b1, 1'b1);
      // Freeze right after an H wrap: line_start must stretch.
      run_to(0, 5);
      repeat (3) step(1'b0, 1'b0);
      // Runs through line 24 (vbl fall) and line 30 (normal line).
      run_to(150, 40);
      repeat (10) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      run_to(200, 150);
      step(1'b1, 1'b1);
      repeat (5) step(1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
